// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_pkg;
    typedef enum logic {FETCH = 1'b0, DISCARD = 1'b1} fetch_state_t;
    localparam int INSTR_BYTES = 4;
    localparam int OP_W = 5;
endpackage

// File: rtl/instr_fifo.sv
// Synchronous prefetch FIFO holding {word, pc} pairs; flush wins over push/pop.
module instr_fifo #(
    parameter int W     = 64,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic [W-1:0]           wdata,
    input  logic                   pop,
    input  logic                   flush,
    output logic [W-1:0]           rdata,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign do_pop  = pop && (count != '0);
    assign do_push = push && ((count != CW'(DEPTH)) || do_pop);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            if (do_push && !do_pop)      count <= count + CW'(1);
            else if (do_pop && !do_push) count <= count - CW'(1);
        end
    end

    // Storage is never reset; validity is tracked by count alone.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= wdata;
    end

    assign rdata = mem[rd_ptr];
endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch/issue unit: imem req/ack, prefetch FIFO, redirect handling.
// Optional FETCH_STATS_EN adds saturating flush_count/stall_count outputs.
module instr_fetch
    import fetch_pkg::*;
#(
    parameter int           N        = 32,
    parameter int           DEPTH    = 4,
    parameter logic [N-1:0] RESET_PC = {N{1'b0}}
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req,
    output logic [N-1:0]    imem_addr,
    input  logic            imem_ack,
    input  logic [N-1:0]    imem_rdata,
    input  logic            redirect,
    input  logic [N-1:0]    redirect_pc,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [N-1:0]    instr,
    output logic [N-1:0]    instr_pc,
    output logic [OP_W-1:0] op
`ifdef FETCH_STATS_EN
    ,
    output logic [15:0]     flush_count,
    output logic [15:0]     stall_count
`endif
);
    localparam int CW = $clog2(DEPTH) + 1;

    fetch_state_t   state_q, state_d;
    logic [N-1:0]   fetch_pc_q, fetch_pc_d;
    logic [N-1:0]   target_q, target_d;
    logic           req_en_q;
    logic           push;
    logic           pop;
    logic [N-1:0]   redirect_aligned;
    logic [2*N-1:0] head;
    logic [CW-1:0]  fifo_count;

    assign redirect_aligned = redirect_pc & ~N'(INSTR_BYTES - 1);

    // req_en holds the request low during reset and for the first cycle after release.
    assign imem_req  = req_en_q && ((state_q == DISCARD) || (fifo_count < CW'(DEPTH)));
    assign imem_addr = fetch_pc_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= FETCH;
            fetch_pc_q <= RESET_PC;
            req_en_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            req_en_q   <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        target_q <= target_d;
    end

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        target_d   = target_q;
        push       = 1'b0;
        case (state_q)
            FETCH: begin
                if (redirect) begin
                    if (imem_req && !imem_ack) begin
                        state_d  = DISCARD;
                        target_d = redirect_aligned;
                    end else begin
                        fetch_pc_d = redirect_aligned;
                    end
                end else if (imem_req && imem_ack) begin
                    push       = 1'b1;
                    fetch_pc_d = fetch_pc_q + N'(INSTR_BYTES);
                end
            end
            DISCARD: begin
                // The in-flight word belongs to the abandoned path and is dropped.
                if (imem_ack) begin
                    state_d    = FETCH;
                    fetch_pc_d = redirect ? redirect_aligned : target_q;
                end else if (redirect) begin
                    target_d = redirect_aligned;
                end
            end
            default: state_d = FETCH;
        endcase
    end

    assign pop = instr_valid && instr_ready;

    instr_fifo #(
        .W     (2 * N),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .wdata ({imem_rdata, fetch_pc_q}),
        .pop   (pop),
        .flush (redirect),
        .rdata (head),
        .count (fifo_count)
    );

    assign instr_valid = (fifo_count != '0);
    assign instr       = instr_valid ? head[2*N-1:N] : '0;
    assign instr_pc    = instr_valid ? head[N-1:0]   : '0;
    assign op          = instr[N-1:N-OP_W];

`ifdef FETCH_STATS_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            flush_count <= '0;
            stall_count <= '0;
        end else begin
            if (redirect && (flush_count != 16'hFFFF))
                flush_count <= flush_count + 16'd1;
            if (!instr_valid && !redirect && (stall_count != 16'hFFFF))
                stall_count <= stall_count + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_instr_fetch.sv
// Randomized scoreboard bench for instr_fetch against a transaction-level fetch model.
module tb_instr_fetch;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [4:0]  op;
`ifdef FETCH_STATS_EN
    logic [15:0] flush_count;
    logic [15:0] stall_count;
`endif

    instr_fetch #(.N(32), .DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
        .clk         (clk),
        .reset       (reset),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .op          (op)
`ifdef FETCH_STATS_EN
        ,
        .flush_count (flush_count),
        .stall_count (stall_count)
`endif
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] salt;
    logic        rst_lvl;

    // Model: fetch address, pending-discard target, FIFO image, scoreboard queue.
    logic [31:0] m_pc;
    logic [31:0] m_tgt;
    logic        m_discard;
    logic        m_run;
    logic [63:0] ref_q[$];
    logic [63:0] exp_q[$];
    int          m_flush;
    int          m_stall;

    function automatic logic [31:0] word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ salt;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc = 32'h0; m_tgt = 32'h0; m_discard = 1'b0; m_run = 1'b0;
        ref_q.delete(); exp_q.delete();
        m_flush = 0; m_stall = 0;
    endtask

    task automatic check_outputs();
        logic mreq;
        mreq = m_run && (m_discard || ref_q.size() < DEPTH);
        chk("imem_req", {31'b0, imem_req}, {31'b0, mreq});
        if (mreq) chk("imem_addr", imem_addr, m_pc);
        chk("instr_valid", {31'b0, instr_valid}, {31'b0, ref_q.size() != 0});
        if (!reset) begin
            chk("rst_instr", instr, 32'h0);
            chk("rst_instr_pc", instr_pc, 32'h0);
            chk("rst_op", {27'b0, op}, 32'h0);
        end
`ifdef FETCH_STATS_EN
        chk("flush_count", {16'b0, flush_count}, m_flush);
        chk("stall_count", {16'b0, stall_count}, m_stall);
`endif
    endtask

    // Advance the model across the coming rising edge using the driven inputs.
    task automatic model_edge();
        logic mreq;
        logic [31:0] tgt;
        mreq = m_run && (m_discard || ref_q.size() < DEPTH);
        tgt  = redirect_pc & 32'hFFFF_FFFC;
        if (!reset) begin
            model_reset();
            return;
        end
        if (redirect && m_flush < 16'hFFFF) m_flush++;
        if (ref_q.size() == 0 && !redirect && m_stall < 16'hFFFF) m_stall++;
        if (redirect) begin
            ref_q.delete(); exp_q.delete();
            if (mreq && !imem_ack) begin
                m_discard = 1'b1; m_tgt = tgt;
            end else begin
                m_discard = 1'b0; m_pc = tgt;
            end
        end else begin
            if (ref_q.size() != 0 && instr_ready) void'(ref_q.pop_front());
            if (mreq && imem_ack) begin
                if (m_discard) begin
                    m_discard = 1'b0; m_pc = m_tgt;
                end else begin
                    ref_q.push_back({word(m_pc), m_pc});
                    exp_q.push_back({word(m_pc), m_pc});
                    m_pc = m_pc + 32'd4;
                end
            end
        end
        m_run = 1'b1;
    endtask

    task automatic step(input logic a, input logic r, input logic rd, input logic [31:0] rp);
        @(negedge clk);
        reset       = rst_lvl;
        imem_ack    = a;
        instr_ready = r;
        redirect    = rd;
        redirect_pc = rp;
        imem_rdata  = a ? word(imem_addr) : $urandom();
        #1;
        check_outputs();
        model_edge();
    endtask

    // Monitor: every issued word is compared against the scoreboard head.
    always begin
        logic [63:0] e;
        @(negedge clk);
        #2;
        if (reset === 1'b1 && instr_valid && instr_ready && !redirect) begin
            if (exp_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL issue_unexpected: got pc %h with no word expected", instr_pc);
            end else begin
                e = exp_q.pop_front();
                chk("issue_instr", instr, e[63:32]);
                chk("issue_pc", instr_pc, e[31:0]);
                chk("issue_op", {27'b0, op}, {27'b0, e[63:59]});
            end
        end
    end

    initial begin
        salt = $urandom();
        rst_lvl = 1'b0; reset = 1'b0;
        imem_ack = 1'b0; imem_rdata = '0; redirect = 1'b0; redirect_pc = '0; instr_ready = 1'b0;
        model_reset();
        repeat (3) step(1'b1, 1'b1, 1'b0, 32'h0);
        rst_lvl = 1'b1;
        // Streaming from reset
        repeat (8) step(1'b1, 1'b1, 1'b0, 32'h0);
        // Fill to full with consumer stalled, then drain and resume
        repeat (8) step(1'b1, 1'b0, 1'b0, 32'h0);
        chk("full_no_req", {31'b0, imem_req}, 32'h0);
        repeat (6) step(1'b0, 1'b1, 1'b0, 32'h0);
        repeat (4) step(1'b1, 1'b1, 1'b0, 32'h0);
        // Flush a partially full FIFO
        repeat (6) step(1'b0, 1'b1, 1'b0, 32'h0);
        repeat (3) step(1'b1, 1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b0, 1'b1, 32'h100);
        repeat (4) step(1'b1, 1'b1, 1'b0, 32'h0);
        // Redirect while a request is outstanding
        step(1'b1, 1'b1, 1'b1, 32'h8);
        step(1'b0, 1'b1, 1'b0, 32'h0);
        step(1'b0, 1'b1, 1'b1, 32'h200);
        repeat (2) step(1'b0, 1'b1, 1'b0, 32'h0);
        step(1'b1, 1'b1, 1'b0, 32'h0);
        repeat (4) step(1'b1, 1'b1, 1'b0, 32'h0);
        // Unaligned target and address wrap
        step(1'b1, 1'b1, 1'b1, 32'h103);
        repeat (3) step(1'b1, 1'b1, 1'b0, 32'h0);
        step(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFC);
        repeat (3) step(1'b1, 1'b1, 1'b0, 32'h0);
        // Asynchronous reset while discarding
        step(1'b0, 1'b1, 1'b1, 32'h40);
        step(1'b0, 1'b1, 1'b0, 32'h0);
        #2;
        reset = 1'b0; rst_lvl = 1'b0;
        #1;
        chk("async_rst_req", {31'b0, imem_req}, 32'h0);
        chk("async_rst_valid", {31'b0, instr_valid}, 32'h0);
        model_reset();
        repeat (2) step(1'b0, 1'b0, 1'b0, 32'h0);
        rst_lvl = 1'b1;
        step(1'b0, 1'b1, 1'b0, 32'h0);
        step(1'b1, 1'b1, 1'b1, 32'h300);
        step(1'b1, 1'b1, 1'b0, 32'h0);
        step(1'b1, 1'b1, 1'b1, 32'h400);
        step(1'b1, 1'b1, 1'b0, 32'h0);
`ifdef FETCH_STATS_EN
        chk("flush_after_two", {16'b0, flush_count}, 32'd2);
`endif
        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] rp;
            rp = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                             : 32'($urandom_range(0, 16'hFFFF));
            step($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 6,
                 $urandom_range(0, 19) == 0, rp);
        end
        repeat (8) step(1'b0, 1'b1, 1'b0, 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
